// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared constants for the 7-segment readback path: active-high
//             segment patterns for digits 0..9 ({g,f,e,d,c,b,a}), FSM state
//             encoding, digit index values, error codes and range limits.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SNAP   = 2'd1,
        ST_DECODE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    // Digit decode order
    localparam logic [2:0] DIG_S1 = 3'd0;
    localparam logic [2:0] DIG_S2 = 3'd1;
    localparam logic [2:0] DIG_M1 = 3'd2;
    localparam logic [2:0] DIG_M2 = 3'd3;
    localparam logic [2:0] DIG_H1 = 3'd4;
    localparam logic [2:0] DIG_H2 = 3'd5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_UNSTABLE = 2'd3;

    localparam logic [6:0] MAX_SM = 7'd59;
    localparam logic [6:0] MAX_H  = 7'd23;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_digit_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_digit_decode
//  Purpose  : Combinational decode of one active-high 7-segment pattern back
//             to a decimal digit. Unknown patterns give valid=0, digit=0.
//  Ports    : pattern in  7  active-high segments {g,f,e,d,c,b,a}
//             valid   out 1  pattern is one of the ten digit shapes
//             digit   out 4  decoded digit 0..9 (0 when invalid)
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic [3:0] digit
);

    always_comb begin
        valid = 1'b1;
        digit = 4'd0;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule : seg7_digit_decode
`default_nettype wire

// File: rtl/seg7_readback.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_readback
//  Purpose  : Snapshots the six 7-segment digit buses on request, decodes
//             one digit per clock through a shared decoder, rebuilds binary
//             h/m/s and range-checks them. Result delivered with a done pulse.
//  Config   : SEG7_RB_STABLE_EN - adds a re-sample/compare stage after the
//             snapshot with up to MAX_RETRY resnapshots (err_code 3 on fail).
//  Ports    : clk, rst_n (sync, active-low), start
//             display_{s1,s2,m1,m2,h1,h2} in 7 - raw segment buses
//             busy, done, rd_s/rd_m/rd_h (6b), err, err_code (2b)
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_readback
    import seg7_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] display_s1,
    input  logic [6:0] display_s2,
    input  logic [6:0] display_m1,
    input  logic [6:0] display_m2,
    input  logic [6:0] display_h1,
    input  logic [6:0] display_h2,
    output logic       busy,
    output logic       done,
    output logic [5:0] rd_s,
    output logic [5:0] rd_m,
    output logic [5:0] rd_h,
    output logic       err,
    output logic [1:0] err_code
);

    state_t      r_state, w_next;
    logic [41:0] r_snap;            // {h2,h1,m2,m1,s2,s1}, active-high
    logic [2:0]  r_idx;
    logic [6:0]  r_acc_s, r_acc_m, r_acc_h;
    logic        r_illegal;
    logic        r_unstable;

    logic [41:0] w_bus_raw, w_bus_fix;
    logic [6:0]  w_pat;
    logic        w_valid;
    logic [3:0]  w_digit;
    logic [3:0]  w_dig_eff;
    logic [6:0]  w_ones, w_tens10;

    assign w_bus_raw = {display_h2, display_h1, display_m2, display_m1, display_s2, display_s1};
    // Polarity is normalised once at capture so everything downstream is active-high
    assign w_bus_fix = (SEG_ACTIVE_LOW != 0) ? ~w_bus_raw : w_bus_raw;

    always_comb begin
        w_pat = r_snap[6:0];
        case (r_idx)
            DIG_S1:  w_pat = r_snap[6:0];
            DIG_S2:  w_pat = r_snap[13:7];
            DIG_M1:  w_pat = r_snap[20:14];
            DIG_M2:  w_pat = r_snap[27:21];
            DIG_H1:  w_pat = r_snap[34:28];
            DIG_H2:  w_pat = r_snap[41:35];
            default: w_pat = r_snap[6:0];
        endcase
    end

    seg7_digit_decode u_dec (
        .pattern (w_pat),
        .valid   (w_valid),
        .digit   (w_digit)
    );

    // Illegal patterns contribute 0; the sticky flag records the failure
    assign w_dig_eff = w_valid ? w_digit : 4'd0;
    assign w_ones    = {3'b000, w_dig_eff};
    assign w_tens10  = (w_ones << 3) + (w_ones << 1);

`ifdef SEG7_RB_STABLE_EN
    logic [7:0] r_retry;
    logic       w_last_retry;
    assign w_last_retry = (r_retry == 8'(MAX_RETRY - 1));
`else
    // Stable-check configuration is inert in this build
    logic unused_stable_cfg;
    assign unused_stable_cfg = (MAX_RETRY != 0) && (ERR_UNSTABLE != ERR_NONE);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
`ifdef SEG7_RB_STABLE_EN
                    w_next = ST_SNAP;
`else
                    w_next = ST_DECODE;
`endif
                end
            end
`ifdef SEG7_RB_STABLE_EN
            ST_SNAP: begin
                if (w_bus_fix == r_snap) w_next = ST_DECODE;
                else if (w_last_retry)   w_next = ST_CHECK;
            end
`endif
            ST_DECODE: if (r_idx == DIG_H2) w_next = ST_CHECK;
            ST_CHECK:  w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Datapath and outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap     <= '0;
            r_idx      <= '0;
            r_acc_s    <= '0;
            r_acc_m    <= '0;
            r_acc_h    <= '0;
            r_illegal  <= 1'b0;
            r_unstable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_s       <= '0;
            rd_m       <= '0;
            rd_h       <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
`ifdef SEG7_RB_STABLE_EN
            r_retry    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_snap     <= w_bus_fix;
                        r_idx      <= DIG_S1;
                        r_acc_s    <= '0;
                        r_acc_m    <= '0;
                        r_acc_h    <= '0;
                        r_illegal  <= 1'b0;
                        r_unstable <= 1'b0;
                        busy       <= 1'b1;
`ifdef SEG7_RB_STABLE_EN
                        r_retry    <= '0;
`endif
                    end
                end
`ifdef SEG7_RB_STABLE_EN
                ST_SNAP: begin
                    if (w_bus_fix != r_snap) begin
                        r_snap  <= w_bus_fix;
                        r_retry <= r_retry + 8'd1;
                        if (w_last_retry) r_unstable <= 1'b1;
                    end
                end
`endif
                ST_DECODE: begin
                    r_idx <= r_idx + 3'd1;
                    if (!w_valid) r_illegal <= 1'b1;
                    case (r_idx)
                        DIG_S1:  r_acc_s <= w_ones;
                        DIG_S2:  r_acc_s <= r_acc_s + w_tens10;
                        DIG_M1:  r_acc_m <= w_ones;
                        DIG_M2:  r_acc_m <= r_acc_m + w_tens10;
                        DIG_H1:  r_acc_h <= w_ones;
                        DIG_H2:  r_acc_h <= r_acc_h + w_tens10;
                        default: ;
                    endcase
                end
                ST_CHECK: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (r_unstable) begin
                        rd_s     <= '0;
                        rd_m     <= '0;
                        rd_h     <= '0;
                        err      <= 1'b1;
                        err_code <= ERR_UNSTABLE;
                    end else begin
                        // Range check uses the full 7-bit sum; outputs keep the low 6 bits
                        rd_s <= r_acc_s[5:0];
                        rd_m <= r_acc_m[5:0];
                        rd_h <= r_acc_h[5:0];
                        if (r_illegal) begin
                            err      <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                        end else if ((r_acc_s > MAX_SM) || (r_acc_m > MAX_SM) || (r_acc_h > MAX_H)) begin
                            err      <= 1'b1;
                            err_code <= ERR_RANGE;
                        end else begin
                            err      <= 1'b0;
                            err_code <= ERR_NONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : seg7_readback
`default_nettype wire

// File: tb/tb_seg7_readback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_readback
//  Purpose  : Self-checking bench for seg7_readback (SEG_ACTIVE_LOW=1).
//             Table of bus images with expected readback, plus sequences for
//             ignored start, back-to-back start, mid-readback reset and,
//             when SEG7_RB_STABLE_EN is defined, the unstable-bus case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_readback;

`ifdef SEG7_RB_STABLE_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 7;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] display_s1 = '1, display_s2 = '1, display_m1 = '1;
    logic [6:0] display_m2 = '1, display_h1 = '1, display_h2 = '1;
    logic       busy, done, err;
    logic [5:0] rd_s, rd_m, rd_h;
    logic [1:0] err_code;

    int checks = 0;
    int failures = 0;

    seg7_readback #(.SEG_ACTIVE_LOW(1), .MAX_RETRY(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .display_s1(display_s1), .display_s2(display_s2),
        .display_m1(display_m1), .display_m2(display_m2),
        .display_h1(display_h1), .display_h2(display_h2),
        .busy(busy), .done(done), .rd_s(rd_s), .rd_m(rd_m), .rd_h(rd_h),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Active-high digit shapes; the bus carries their complement
    function automatic logic [6:0] raw_digit(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'h3F; 1: p = 7'h06; 2: p = 7'h5B; 3: p = 7'h4F; 4: p = 7'h66;
            5: p = 7'h6D; 6: p = 7'h7D; 7: p = 7'h07; 8: p = 7'h7F; default: p = 7'h6F;
        endcase
        return ~p;
    endfunction

    function automatic logic [41:0] mk_bus(input int h, input int m, input int s);
        return {raw_digit(h / 10), raw_digit(h % 10), raw_digit(m / 10),
                raw_digit(m % 10), raw_digit(s / 10), raw_digit(s % 10)};
    endfunction

    task automatic drive_bus(input logic [41:0] b);
        {display_h2, display_h1, display_m2, display_m1, display_s2, display_s1} = b;
    endtask

    typedef struct {
        string       name;
        logic [41:0] bus;
        int          h, m, s;
        logic        err;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[7];

    // Pulses start, scrambles the buses after the snapshot, returns done latency
    task automatic run_readback(input logic [41:0] bus, output int lat);
        @(negedge clk); drive_bus(bus); start = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_start", busy, 1);
        @(negedge clk); start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) drive_bus({6{7'h7F}});
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone, first_n, second_n;
        logic [41:0] b;

        vecs[0] = '{"t235959", mk_bus(23, 59, 59), 23, 59, 59, 1'b0, 2'd0};
        vecs[1] = '{"t000000", {6{7'h40}},         0,  0,  0, 1'b0, 2'd0};
        b = mk_bus(12, 34, 56); b[20:14] = 7'h7F;
        vecs[2] = '{"blank_m1", b,                 12, 30, 56, 1'b1, 2'd1};
        vecs[3] = '{"t246100", mk_bus(24, 61, 0),  24, 61,  0, 1'b1, 2'd2};
        vecs[4] = '{"t190742", mk_bus(19, 7, 42),  19,  7, 42, 1'b0, 2'd0};
        b = mk_bus(29, 0, 5); b[13:7] = 7'h7F;
        vecs[5] = '{"illegal_over_range", b,       29,  0,  5, 1'b1, 2'd1};
        vecs[6] = '{"t099999_trunc", mk_bus(9, 99, 99), 9, 35, 35, 1'b1, 2'd2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd", {rd_h, rd_m, rd_s}, 0);
        chk("reset_err", {err, err_code}, 0);
        @(negedge clk); rst_n = 1'b1;

        // Table-driven readbacks
        for (int i = 0; i < 7; i++) begin
            run_readback(vecs[i].bus, lat);
            chk({vecs[i].name, "_latency"}, lat, LAT);
            chk({vecs[i].name, "_rd_h"}, rd_h, vecs[i].h);
            chk({vecs[i].name, "_rd_m"}, rd_m, vecs[i].m);
            chk({vecs[i].name, "_rd_s"}, rd_s, vecs[i].s);
            chk({vecs[i].name, "_err"}, err, vecs[i].err);
            chk({vecs[i].name, "_err_code"}, err_code, vecs[i].code);
            @(posedge clk); #1;
            chk({vecs[i].name, "_done_pulse"}, done, 0);
            chk({vecs[i].name, "_hold_rd_h"}, rd_h, vecs[i].h);
            chk({vecs[i].name, "_hold_busy"}, busy, 0);
        end

        // start re-pulsed while busy is ignored: exactly one done
        @(negedge clk); drive_bus(mk_bus(1, 2, 3)); start = 1'b1;
        ndone = 0; first_n = -1;
        for (int n = 0; n <= 24; n++) begin
            @(posedge clk); #1;
            if (done) begin ndone++; if (first_n < 0) first_n = n; end
            @(negedge clk);
            start = (n == 2);
        end
        chk("repulse_done_count", ndone, 1);
        chk("repulse_latency", first_n, LAT);
        chk("repulse_rd_s", rd_s, 3);

        // start held high across the done cycle: second readback follows at once
        @(negedge clk); drive_bus(mk_bus(4, 5, 6)); start = 1'b1;
        ndone = 0; first_n = -1; second_n = -1;
        for (int n = 0; n <= 26; n++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first_n < 0) first_n = n; else second_n = n;
            end
            @(negedge clk);
            if (ndone >= 2) start = 1'b0;
        end
        start = 1'b0;
        chk("b2b_done_count", ndone, 2);
        chk("b2b_first", first_n, LAT);
        chk("b2b_second", second_n, 2 * LAT + 1);
        chk("b2b_rd_m", rd_m, 5);

        // Reset mid-readback: no done, outputs cleared
        @(negedge clk); drive_bus(mk_bus(22, 33, 44)); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rd", {rd_h, rd_m, rd_s}, 0);
        chk("midrst_err", {err, err_code}, 0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);

`ifdef SEG7_RB_STABLE_EN
        // Bus toggling every cycle exhausts the retries
        @(negedge clk); drive_bus(mk_bus(10, 20, 30)); start = 1'b1;
        lat = -1;
        for (int n = 0; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
            @(negedge clk);
            start = 1'b0;
            display_s1 = display_s1 ^ 7'h01;
        end
        chk("unstable_seen_done", (lat > 0), 1);
        chk("unstable_err", err, 1);
        chk("unstable_code", err_code, 3);
        chk("unstable_rd", {rd_h, rd_m, rd_s}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seg7_readback
`default_nettype wire
